// File: rtl/rf_controller.sv
// rf_controller: multi-cycle read/execute/write-back initiator for the 4x8 register file (optional saturating ADD/SUB under RF_CTRL_SAT_ARITH_EN)
module rf_controller #(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 2
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [2:0]         op,
  input  logic [RADDR_W-1:0] rd,
  input  logic [RADDR_W-1:0] rs1,
  input  logic [RADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0]  imm,
  output logic [RADDR_W-1:0] regA,
  output logic [RADDR_W-1:0] regB,
  input  logic [DATA_W-1:0]  dataA,
  input  logic [DATA_W-1:0]  dataB,
  output logic               RFWrite,
  output logic [RADDR_W-1:0] regW,
  output logic [DATA_W-1:0]  dataW,
  output logic               done,
  output logic               flag_z,
  output logic               flag_n,
  output logic               flag_c
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  state_t state, state_nxt;
  logic [2:0] op_q;
  logic [RADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q, opa, opb, res;
  logic [DATA_W:0] sum, diff;
  logic c_res, accept;
  assign accept = instr_valid & instr_ready;
  assign sum = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};
  // state register; reset aborts any in-flight instruction
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // next state; LOAD skips the read phase; write strobes are decoded from state so reset drops them at once
  always_comb begin
    instr_ready = state == IDLE;
    RFWrite = state == WRITE;
    done = state == WRITE;
    state_nxt = state == IDLE ? (instr_valid ? (op == 3'd0 ? EXEC : READ) : IDLE) :
                state == READ ? EXEC :
                state == EXEC ? WRITE : IDLE;
  end
  // ALU; carry is the raw carry/borrow/shifted-out bit even when the result saturates
  always_comb begin
    res = op_q == 3'd0 ? imm_q :
          op_q == 3'd1 ? sum[DATA_W-1:0] :
          op_q == 3'd2 ? diff[DATA_W-1:0] :
          op_q == 3'd3 ? opa & opb :
          op_q == 3'd4 ? opa | opb :
          op_q == 3'd5 ? opa ^ opb :
          op_q == 3'd6 ? {opa[DATA_W-2:0], 1'b0} : opa;
    c_res = op_q == 3'd1 ? sum[DATA_W] :
            op_q == 3'd2 ? diff[DATA_W] :
            op_q == 3'd6 ? opa[DATA_W-1] : 1'b0;
`ifdef RF_CTRL_SAT_ARITH_EN
    if (op_q == 3'd1 && c_res) res = '1;
    if (op_q == 3'd2 && c_res) res = '0;
`endif
  end
  // datapath: latch instruction on accept, capture operands in READ, register result and flags in EXEC
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      op_q <= '0;
      rd_q <= '0;
      imm_q <= '0;
      opa <= '0;
      opb <= '0;
      regA <= '0;
      regB <= '0;
      regW <= '0;
      dataW <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op;
        rd_q <= rd;
        imm_q <= imm;
        if (op != 3'd0) begin
          regA <= rs1;
          regB <= rs2;
        end
      end
      if (state == READ) begin
        opa <= dataA;
        opb <= dataB;
      end
      if (state == EXEC) begin
        dataW <= res;
        regW <= rd_q;
        flag_z <= res == '0;
        flag_n <= res[DATA_W-1];
        flag_c <= c_res;
      end
    end
endmodule

// File: tb/tb_rf_controller.sv
// tb_rf_controller: directed table, back-to-back, reset-abort and random checks of rf_controller against a register-file model
module tb_rf_controller;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b0;
  logic instr_valid = 1'b0;
  logic instr_ready;
  logic [2:0] op = '0;
  logic [1:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [7:0] imm = '0;
  logic [1:0] regA, regB, regW;
  logic [7:0] dataA, dataB, dataW;
  logic RFWrite, done, flag_z, flag_n, flag_c;
  logic [7:0] rf [4];
  logic [7:0] rf_m [4];
  int total = 0, bad = 0, cyc = 0;
  int wc [$];
  logic [1:0] wa [$];
  logic [7:0] wd [$];

  rf_controller dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .regA(regA), .regB(regB),
    .dataA(dataA), .dataB(dataB), .RFWrite(RFWrite), .regW(regW), .dataW(dataW),
    .done(done), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  assign dataA = rf[regA];
  assign dataB = rf[regB];

  always @(posedge CLOCK_50) begin
    if (RFWrite) rf[regW] <= dataW;
    cyc <= cyc + 1;
  end

  always @(negedge CLOCK_50)
    if (RFWrite) begin
      wc.push_back(cyc);
      wa.push_back(regW);
      wd.push_back(dataW);
    end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] im, output logic [7:0] r, output logic c);
    int x, y, f;
    x = a;
    y = b;
    case (o)
      3'd0: f = im;
      3'd1: f = x + y;
      3'd2: f = x - y;
      3'd3: f = a & b;
      3'd4: f = a | b;
      3'd5: f = a ^ b;
      3'd6: f = x * 2;
      default: f = x;
    endcase
    c = (o == 3'd1 || o == 3'd6) ? f > 255 : o == 3'd2 ? f < 0 : 1'b0;
    r = f[7:0];
`ifdef RF_CTRL_SAT_ARITH_EN
    if (c && o == 3'd1) r = 8'hFF;
    if (c && o == 3'd2) r = 8'h00;
`endif
  endfunction

  task automatic run(input string nm, input logic [2:0] o, input logic [1:0] d, input logic [1:0] s1,
                     input logic [1:0] s2, input logic [7:0] im, input logic [7:0] er, input logic ec);
    int n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 10) chk({nm, "_idle_timeout"}, 0, 1);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; instr_valid = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    instr_valid = 1'b0;
    op = 3'($urandom); rd = 2'($urandom); rs1 = 2'($urandom); rs2 = 2'($urandom); imm = 8'($urandom);
    n = 1;
    while (!RFWrite && n < 6) begin
      chk({nm, "_busy_ready"}, instr_ready, 0);
      if (n == 1 && o != 3'd0) begin
        chk({nm, "_regA"}, regA, s1);
        chk({nm, "_regB"}, regB, s2);
      end
      @(negedge CLOCK_50);
      n++;
    end
    chk({nm, "_latency"}, n, o == 3'd0 ? 2 : 3);
    chk({nm, "_regW"}, regW, d);
    chk({nm, "_dataW"}, dataW, er);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_wr_ready"}, instr_ready, 0);
    @(negedge CLOCK_50);
    rf_m[d] = er;
    chk({nm, "_after_RFWrite"}, RFWrite, 0);
    chk({nm, "_after_done"}, done, 0);
    chk({nm, "_after_ready"}, instr_ready, 1);
    chk({nm, "_regW_hold"}, regW, d);
    chk({nm, "_dataW_hold"}, dataW, er);
    chk({nm, "_rf"}, rf[d], er);
    chk({nm, "_flag_c"}, flag_c, ec);
    chk({nm, "_flag_z"}, flag_z, er == 8'h00);
    chk({nm, "_flag_n"}, flag_n, er[7]);
  endtask

  typedef struct {
    string nm;
    logic [2:0] o;
    logic [1:0] d, s1, s2;
    logic [7:0] im, r;
    logic c;
  } vec_t;
  vec_t tbl [12];

  initial begin
    logic [7:0] r;
    logic c;
    logic [2:0] bo [4];
    logic [1:0] bd [4], bs1 [4], bs2 [4];
    logic [7:0] bim [4], br [4];
    int ac [4];
    int n;
    for (int i = 0; i < 4; i++) begin
      rf[i] = 8'h00;
      rf_m[i] = 8'h00;
    end
    tbl[0]  = '{"load_r1",  3'd0, 2'd1, 2'd0, 2'd0, 8'h5A, 8'h5A, 1'b0};
    tbl[1]  = '{"load_r0",  3'd0, 2'd0, 2'd0, 2'd0, 8'hF0, 8'hF0, 1'b0};
    tbl[2]  = '{"load_r2",  3'd0, 2'd2, 2'd0, 2'd0, 8'h20, 8'h20, 1'b0};
`ifdef RF_CTRL_SAT_ARITH_EN
    tbl[3]  = '{"add_carry", 3'd1, 2'd3, 2'd0, 2'd2, 8'h00, 8'hFF, 1'b1};
`else
    tbl[3]  = '{"add_carry", 3'd1, 2'd3, 2'd0, 2'd2, 8'h00, 8'h10, 1'b1};
`endif
    tbl[4]  = '{"sub_same", 3'd2, 2'd1, 2'd2, 2'd2, 8'h00, 8'h00, 1'b0};
    tbl[5]  = '{"load_81",  3'd0, 2'd0, 2'd0, 2'd0, 8'h81, 8'h81, 1'b0};
    tbl[6]  = '{"shl",      3'd6, 2'd0, 2'd0, 2'd0, 8'h00, 8'h02, 1'b1};
    tbl[7]  = '{"and",      3'd3, 2'd3, 2'd0, 2'd2, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{"or",       3'd4, 2'd3, 2'd0, 2'd2, 8'h00, 8'h22, 1'b0};
    tbl[9]  = '{"xor_same", 3'd5, 2'd1, 2'd2, 2'd2, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{"mov",      3'd7, 2'd1, 2'd2, 2'd0, 8'h00, 8'h20, 1'b0};
`ifdef RF_CTRL_SAT_ARITH_EN
    tbl[11] = '{"sub_borrow", 3'd2, 2'd3, 2'd0, 2'd2, 8'h00, 8'h00, 1'b1};
`else
    tbl[11] = '{"sub_borrow", 3'd2, 2'd3, 2'd0, 2'd2, 8'h00, 8'hE2, 1'b1};
`endif

    #1 reset = 1'b1;
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_RFWrite", RFWrite, 0);
    chk("rst_done", done, 0);
    chk("rst_regA", regA, 0);
    chk("rst_regB", regB, 0);
    chk("rst_regW", regW, 0);
    chk("rst_dataW", dataW, 0);
    chk("rst_flags", {flag_z, flag_n, flag_c}, 0);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);

    for (int i = 0; i < 12; i++)
      run(tbl[i].nm, tbl[i].o, tbl[i].d, tbl[i].s1, tbl[i].s2, tbl[i].im, tbl[i].r, tbl[i].c);

    bo = '{3'd0, 3'd1, 3'd0, 3'd2};
    bd = '{2'd2, 2'd3, 2'd1, 2'd0};
    bs1 = '{2'd0, 2'd2, 2'd0, 2'd3};
    bs2 = '{2'd0, 2'd2, 2'd0, 2'd1};
    bim = '{8'h33, 8'h00, 8'h07, 8'h00};
    for (int i = 0; i < 4; i++) begin
      model(bo[i], rf_m[bs1[i]], rf_m[bs2[i]], bim[i], br[i], c);
      rf_m[bd[i]] = br[i];
    end
    wc.delete(); wa.delete(); wd.delete();
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = bo[i]; rd = bd[i]; rs1 = bs1[i]; rs2 = bs2[i]; imm = bim[i];
      n = 0;
      while (!instr_ready && n < 10) begin
        @(negedge CLOCK_50);
        n++;
      end
      chk("b2b_accept_in_time", n < 10, 1);
      ac[i] = cyc;
      @(negedge CLOCK_50);
    end
    instr_valid = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    chk("b2b_write_count", wc.size(), 4);
    for (int i = 0; i < 4 && i < wc.size(); i++) begin
      chk("b2b_write_cycle", wc[i] - ac[i], bo[i] == 3'd0 ? 2 : 3);
      chk("b2b_write_addr", wa[i], bd[i]);
      chk("b2b_write_data", wd[i], br[i]);
      chk("b2b_rf", rf[bd[i]], rf_m[bd[i]]);
      if (i < 3) chk("b2b_gap", ac[i+1] - ac[i], bo[i] == 3'd0 ? 3 : 4);
    end

    wc.delete();
    op = 3'd1; rd = 2'd3; rs1 = 2'd0; rs2 = 2'd2; instr_valid = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    instr_valid = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    chk("abort_RFWrite", RFWrite, 0);
    chk("abort_flags", {flag_z, flag_n, flag_c}, 0);
    chk("abort_ready_in_reset", instr_ready, 1);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("abort_ready_after", instr_ready, 1);
    chk("abort_no_write", wc.size(), 0);
    chk("abort_r3_unchanged", rf[3], rf_m[3]);
    chk("abort_flags_after", {flag_z, flag_n, flag_c}, 0);

    for (int i = 0; i < 30; i++) begin
      logic [2:0] o;
      logic [1:0] d, s1, s2;
      logic [7:0] im;
      o = 3'($urandom_range(0, 7));
      d = 2'($urandom);
      s1 = 2'($urandom);
      s2 = 2'($urandom);
      im = 8'($urandom);
      model(o, rf_m[s1], rf_m[s2], im, r, c);
      run("rnd", o, d, s1, s2, im, r, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_controller.md
Name: rf_controller

Overview:
- Multi-cycle initiator for the 4x8 register file.
- Accepts one instruction at a time over a valid/ready handshake.
- Drives the file's two read-address ports, captures the read data, computes an ALU result and writes it back through the file's write port.
- Sits between any instruction source (switch decoder, ROM sequencer) and the register file.

Parameters:
- DATA_W, 8, datapath and register width; must match the register file.
- RADDR_W, 2, register address width (4 registers).

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction present on op/rd/rs1/rs2/imm.
- instr_ready  out  1  controller can accept an instruction.
- op  in  3  opcode.
- rd  in  RADDR_W  destination register.
- rs1  in  RADDR_W  source register A.
- rs2  in  RADDR_W  source register B.
- imm  in  DATA_W  immediate for LOAD.
- regA  out  RADDR_W  register-file read address A.
- regB  out  RADDR_W  register-file read address B.
- dataA  in  DATA_W  register-file read data A (combinational from regA).
- dataB  in  DATA_W  register-file read data B (combinational from regB).
- RFWrite  out  1  register-file write enable.
- regW  out  RADDR_W  register-file write address.
- dataW  out  DATA_W  register-file write data.
- done  out  1  one-cycle pulse when the write-back cycle occurs.
- flag_z  out  1  last result was zero.
- flag_n  out  1  last result MSB.
- flag_c  out  1  carry out (ADD), borrow (SUB), shifted-out bit (SHL); 0 otherwise.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; regA, regB, regW, dataW = 0; RFWrite = 0; done = 0; all flags = 0; latched instruction cleared.
- instr_ready = 1 exactly when state is IDLE. Handshakes are ignored while reset is high.
- States:
  - IDLE: on instr_valid & instr_ready at a rising edge, latch op/rd/rs1/rs2/imm. Go to EXEC if op = LOAD, otherwise READ.
  - READ: regA = rs1 and regB = rs2 (registered, driven from the latched fields). At the edge, capture dataA/dataB into operand registers, then go to EXEC.
  - EXEC: compute result and flags from the operands. At the edge, register them into dataW and flag_*, then go to WRITE.
  - WRITE: RFWrite = 1, regW = rd, dataW = result, done = 1 for exactly this cycle. Next state IDLE.
- Opcodes (arithmetic modulo 2^DATA_W):
  - 000 LOAD: imm
  - 001 ADD: A+B
  - 010 SUB: A-B
  - 011 AND
  - 100 OR
  - 101 XOR
  - 110 SHL: A<<1
  - 111 MOV: A
- Latency, with acceptance edge at cycle T:
  - ALU ops: WRITE occupies cycle T+3; the register updates at the end of T+3; instr_ready is high again in T+4.
  - LOAD: one cycle shorter (WRITE in T+2).
- Throughput: one ALU op per 4 cycles, one LOAD per 3 cycles.
- Back-to-back dependent instructions need no bypass: a write completes before the next READ.
- RFWrite is never high outside WRITE. regW and dataW hold their last values after WRITE. regA and regB hold their last values.
- rs1 = rs2 is legal; both ports read the same register.
- rd equal to rs1 or rs2 is legal; the operands were captured in READ.
- instr_valid dropping or fields changing while not in IDLE has no effect.
- Reset asserted in READ or EXEC: no write occurs.
- Reset asserted in WRITE: RFWrite drops immediately. Whether that edge's write lands depends only on assertion timing relative to the edge; the bench must not rely on it.

Optional Feature:
- Macro: RF_CTRL_SAT_ARITH_EN.
- Defined: ADD clamps to 2^DATA_W-1 on carry out; SUB clamps to 0 on borrow. flag_c still reports the raw carry/borrow. flag_z and flag_n reflect the clamped result.
- Undefined: ADD and SUB wrap modulo 2^DATA_W.
- All other opcodes are identical in both builds.

Test Plan:
- Reset, then LOAD rd=1 imm=0x5A -> RFWrite high exactly 2 cycles after acceptance with regW=1, dataW=0x5A; done pulses once; r1 reads back 0x5A.
- LOAD r0=0xF0, LOAD r2=0x20, ADD rd=3 rs1=0 rs2=2:
  - default build -> r3=0x10, flag_c=1, flag_z=0.
  - with RF_CTRL_SAT_ARITH_EN -> r3=0xFF, flag_c=1.
- SUB rd=1 rs1=2 rs2=2 with r2=0x20 -> r1=0x00, flag_z=1, flag_c=0. SHL rd=0 rs1=0 with r0=0x81 -> r0=0x02, flag_c=1, flag_n=0.
- Hold instr_valid high with four instructions queued back-to-back -> instr_ready low in non-IDLE cycles; exactly one write per instruction, at cycles T+3 (or T+2 for LOAD). A dependent ADD reads the value written by the preceding LOAD.
- Assert reset during EXEC of ADD rd=3 -> RFWrite never rises, r3 unchanged, flags=0, instr_ready=1 on the first cycle after release.
- Change op/rd/instr_valid during READ/EXEC -> the written value and address match the latched instruction only.
